// File: rtl/float_divider.sv
// float_divider
// Sequential IEEE-754 single-precision divider using a bit-serial restoring
// mantissa division (one quotient bit per clock). The result is normalised,
// truncated and packed. There is no rounding and no NaN, infinity or denormal
// handling. The only special cases are an exact zero dividend and an exact
// zero divisor.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      operation request, sampled only while idle
//   a, b       dividend / divisor, captured on the accepted start edge
//   quotient   result register, updated only on the done edge
//   busy       high while an operation is in flight
//   done       one-cycle completion pulse, quotient valid in that cycle
//   divByZero  set with done when b was exactly zero, cleared on next start
module float_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] quotient,
    output logic        busy,
    output logic        done,
    output logic        divByZero
);

    typedef enum logic [1:0] {IDLE, CALC, NORM} stateT;

    stateT       state;
    stateT       nextState;

    logic [31:0] aReg;
    logic [31:0] bReg;
    logic [24:0] rem;
    logic [24:0] div;
    logic [24:0] q;
    logic [4:0]  cnt;
    logic        special;

    logic        remGe;
    logic [23:0] diff;
    logic        sign;
    logic [7:0]  expBase;
    logic [31:0] normResult;
    logic        normDz;

    // When rem >= div, the true difference is below div (< 2^24), so the low
    // 24 bits of the subtraction are the complete remainder.
    assign remGe = (rem >= div);
    assign diff  = rem[23:0] - div[23:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. Zero operands bypass the iterative division entirely.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((a == 32'b0) || (b == 32'b0)) begin
                        nextState = NORM;
                    end else begin
                        nextState = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt == 5'd24) begin
                    nextState = NORM;
                end
            end
            NORM:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Packing of the final result. The exponent is 8-bit modulo-256, so
    // overflow and underflow wrap silently. A 25-bit quotient with bit 24 set
    // means the mantissa ratio was >= 1.0, otherwise the point moves one place.
    always_comb begin
        normResult = 32'b0;
        normDz     = 1'b0;
        sign       = aReg[31] ^ bReg[31];
        expBase    = aReg[30:23] - bReg[30:23];
        if (special) begin
            if (bReg == 32'b0) begin
                normResult = {sign, 8'hFF, 23'b0};
                normDz     = 1'b1;
            end else begin
                normResult = 32'b0;
            end
        end else if (q[24]) begin
            normResult = {sign, expBase + 8'd127, q[23:1]};
        end else begin
            normResult = {sign, expBase + 8'd126, q[22:0]};
        end
    end

    // Datapath and registered outputs. Operands are captured only in IDLE, so
    // a start pulse during an operation cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aReg      <= 32'b0;
            bReg      <= 32'b0;
            rem       <= 25'b0;
            div       <= 25'b0;
            q         <= 25'b0;
            cnt       <= 5'b0;
            special   <= 1'b0;
            quotient  <= 32'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        aReg      <= a;
                        bReg      <= b;
                        divByZero <= 1'b0;
                        busy      <= 1'b1;
                        special   <= (a == 32'b0) || (b == 32'b0);
                        rem       <= {2'b01, a[22:0]};
                        div       <= {2'b01, b[22:0]};
                        q         <= 25'b0;
                        cnt       <= 5'b0;
                    end
                end
                CALC: begin
                    if (remGe) begin
                        q   <= {q[23:0], 1'b1};
                        rem <= {diff, 1'b0};
                    end else begin
                        q   <= {q[23:0], 1'b0};
                        rem <= {rem[23:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    quotient  <= normResult;
                    divByZero <= normDz;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_divider.sv
// tb_float_divider
// Self-checking bench for float_divider. Expected results come from a
// behavioural model that divides the mantissas with plain integer arithmetic
// and applies the simplified packing rules.
module tb_float_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] quotient;
    logic        busy;
    logic        done;
    logic        divByZero;

    int assertions = 0;
    int failures   = 0;

    float_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .quotient  (quotient),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    // busy and done must never be high together
    always @(negedge clk) begin
        assertions++;
        if (busy && done) begin
            failures++;
            $display("[TB] FAIL busyDoneExclusive: busy=%b done=%b, required not both high", busy, done);
        end
    end

    // Reference model: exact integer ratio of the 24-bit significands scaled
    // by 2^24, truncated; then packed with modulo-256 exponent arithmetic.
    function automatic logic [31:0] refQuot(input logic [31:0] x, input logic [31:0] y);
        longint unsigned num;
        longint unsigned den;
        longint unsigned r;
        logic [7:0]      e;
        logic            s;
        s = x[31] ^ y[31];
        if (y == 32'b0) return {s, 8'hFF, 23'b0};
        if (x == 32'b0) return 32'b0;
        num = longint'({1'b1, x[22:0]}) << 24;
        den = longint'({1'b1, y[22:0]});
        r   = num / den;
        if (r >= (longint'(1) << 24)) begin
            e = x[30:23] - y[30:23] + 8'd127;
            return {s, e, r[23:1]};
        end else begin
            e = x[30:23] - y[30:23] + 8'd126;
            return {s, e, r[22:0]};
        end
    endfunction

    // Drives one operation starting #1 after an edge with the DUT idle;
    // returns #1 after the done edge (or after the cycle budget expires).
    task automatic runOp(input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [31:0] qOut,
                         output logic dz, output logic busyAtStart);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busyAtStart = busy;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        qOut = quotient;
        dz = divByZero;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = 32'b0;
        b = 32'b0;
        #12;
        assertions++;
        if (quotient !== 32'b0) begin failures++; $display("[TB] FAIL resetQuotient: got %h, required 00000000", quotient); end
        assertions++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL resetBusy: got %b, required 0", busy); end
        assertions++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL resetDone: got %b, required 0", done); end
        assertions++;
        if (divByZero !== 1'b0) begin failures++; $display("[TB] FAIL resetDivByZero: got %b, required 0", divByZero); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed(input string name, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] expQ, input logic expDz, input int expLat);
        int          lat;
        logic [31:0] qOut;
        logic        dz;
        logic        bs;
        runOp(x, y, lat, qOut, dz, bs);
        assertions++;
        if (qOut !== expQ) begin failures++; $display("[TB] FAIL %s quotient: got %h, required %h", name, qOut, expQ); end
        assertions++;
        if (dz !== expDz) begin failures++; $display("[TB] FAIL %s divByZero: got %b, required %b", name, dz, expDz); end
        assertions++;
        if (lat != expLat) begin failures++; $display("[TB] FAIL %s latency: got %0d, required %0d", name, lat, expLat); end
        assertions++;
        if (bs !== 1'b1) begin failures++; $display("[TB] FAIL %s busyAfterStart: got %b, required 1", name, bs); end
        @(posedge clk);
        #1;
    endtask

    // divByZero from a previous operation is cleared on the next accepted start
    task automatic test_dz_clear();
        int          lat;
        logic [31:0] qOut;
        logic        dz;
        logic        bs;
        a = 32'h40A00000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        assertions++;
        if (divByZero !== 1'b0) begin failures++; $display("[TB] FAIL dzClearOnStart: got %b, required 0", divByZero); end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        assertions++;
        if (quotient !== refQuot(32'h40A00000, 32'h40000000)) begin
            failures++;
            $display("[TB] FAIL dzClearResult: got %h, required %h", quotient, refQuot(32'h40A00000, 32'h40000000));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] x;
        logic [31:0] y;
        int          lat;
        logic [31:0] qOut;
        logic        dz;
        logic        bs;
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            y = $urandom;
            if (x == 32'b0) x = 32'h3F800000;
            if (y == 32'b0) y = 32'h40400000;
            runOp(x, y, lat, qOut, dz, bs);
            assertions++;
            if (qOut !== refQuot(x, y) || dz !== 1'b0 || lat != 26) begin
                failures++;
                $display("[TB] FAIL random%0d %h/%h: got q=%h dz=%b lat=%0d, required q=%h dz=0 lat=26",
                         i, x, y, qOut, dz, lat, refQuot(x, y));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_while_busy();
        int lat;
        int extraDone;
        a = 32'h40C00000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        a = 32'h3F800000;
        b = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        assertions++;
        if (quotient !== 32'h40400000) begin failures++; $display("[TB] FAIL busyIgnoreResult: got %h, required 40400000", quotient); end
        assertions++;
        if (lat != 26) begin failures++; $display("[TB] FAIL busyIgnoreLatency: got %0d, required 26", lat); end
        extraDone = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extraDone++;
        end
        assertions++;
        if (extraDone != 0) begin failures++; $display("[TB] FAIL busyIgnoreExtraDone: got %0d, required 0", extraDone); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] qOut;
        logic        dz;
        logic        bs;
        runOp(32'hC1000000, 32'h3F000000, lat, qOut, dz, bs);
        assertions++;
        if (qOut !== 32'hC1800000) begin failures++; $display("[TB] FAIL b2bFirst: got %h, required c1800000", qOut); end
        runOp(32'h3F800000, 32'h40400000, lat, qOut, dz, bs);
        assertions++;
        if (qOut !== 32'h3EAAAAAA) begin failures++; $display("[TB] FAIL b2bSecond: got %h, required 3eaaaaaa", qOut); end
        assertions++;
        if (lat != 26) begin failures++; $display("[TB] FAIL b2bLatency: got %0d, required 26", lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        int          lat;
        int          sawDone;
        logic [31:0] qOut;
        logic        dz;
        logic        bs;
        a = 32'h40C00000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        assertions++;
        if (quotient !== 32'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midReset: got q=%h busy=%b done=%b, required q=00000000 busy=0 done=0", quotient, busy, done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sawDone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) sawDone++;
        end
        assertions++;
        if (sawDone != 0) begin failures++; $display("[TB] FAIL midResetNoDone: got %0d done pulses, required 0", sawDone); end
        runOp(32'hC1000000, 32'h3F000000, lat, qOut, dz, bs);
        assertions++;
        if (qOut !== 32'hC1800000 || lat != 26) begin
            failures++;
            $display("[TB] FAIL afterReset: got q=%h lat=%0d, required q=c1800000 lat=26", qOut, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed("exact",    32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);
        test_directed("oneThird", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26);
        test_directed("signExp",  32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0, 26);
        test_directed("zeroA",    32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 1);
        test_directed("zeroB",    32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1);
        test_dz_clear();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/float_divider.md
# float_divider

Sequential IEEE-754 single-precision divider, the inverse companion of the combinational float multiplier in the arithmetic datapath. Accepts operands on a start pulse, computes a/b by a bit-serial restoring mantissa division (one quotient bit per clock), then normalises, truncates and packs the result. It uses the same simplified format rules as the multiplier:
- no rounding;
- no NaN, infinity or denormal handling;
- exact-zero special case only.

## Interface
- No parameters; fixed to 32-bit single precision.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- a  input  32  dividend, captured on the accepted start edge.
- b  input  32  divisor, captured on the accepted start edge.
- quotient  output  32  result register; holds its value until the next completion.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle completion pulse; quotient is valid in that cycle.
- divByZero  output  1  set with done when b was 32'b0; cleared on the next accepted start.

## Operation
- States: IDLE, CALC, NORM.
- IDLE, start=1: register the operands and clear divByZero, then branch:
  - a==32'b0 or b==32'b0 (exact compare): go to NORM with special flag set.
  - otherwise: load rem = {1'b1,a[22:0]} (25-bit), div = {1'b1,b[22:0]}, cnt=0, go to CALC.
- CALC, each cycle:
  - if rem >= div then q = {q[23:0],1}, rem = (rem-div)<<1;
  - else q = {q[23:0],0}, rem = rem<<1.
  - cnt increments; after 25 iterations (cnt==24 step) go to NORM.
- NORM, one cycle; sign = a[31]^b[31]; result written to quotient:
  - b==0: quotient = {sign, 8'hFF, 23'b0}, divByZero=1.
  - a==0 and b!=0: quotient = 32'b0.
  - q[24]==1: mant = q[23:1], exp = aExp - bExp + 127.
  - q[24]==0: mant = q[22:0], exp = aExp - bExp + 126.
  - Exponent is 8-bit modulo-256 arithmetic; overflow and underflow wrap silently, as in the multiplier.
  - Extra quotient bits are discarded (truncation toward zero magnitude).
  - done=1 for this one cycle, then return to IDLE.
- start while busy: ignored; the operation in flight is unaffected and the operands are not re-sampled.

## Timing
- Reset values: quotient=0, busy=0, done=0, divByZero=0, state IDLE. Reset asserted mid-operation aborts immediately; no done is produced afterwards.
- Accepted start at edge E0: busy=1 from E0.
- Normal path: CALC iterations occupy edges E1..E25; NORM result, done=1 and busy=0 at edge E26. Latency is 26 cycles.
- Special path (a or b zero): done=1 and busy=0 at edge E1. Latency is 1 cycle.
- done and busy are never high together.
- start in the done cycle (state IDLE) is accepted: back-to-back throughput is one operation per 27 cycles.
- quotient changes only at the done edge; it is stable at all other times, including during busy.

## Test plan
- Exact division: a=0x40C00000 (6.0), b=0x40000000 (2.0), start -> 26 cycles later done=1, quotient=0x40400000, divByZero=0.
- Truncation and normalisation with q[24]=0: 0x3F800000 / 0x40400000 (1/3) -> quotient=0x3EAAAAAA (not ...AB).
- Sign and exponent: 0xC1000000 / 0x3F000000 (-8/0.5) -> quotient=0xC1800000.
- Zero cases:
  - 0x00000000 / 0x40A00000 -> done 1 cycle after start, quotient=0, divByZero=0.
  - 0x3F800000 / 0x00000000 -> done after 1 cycle, quotient=0x7F800000, divByZero=1.
- Handshake:
  - start re-pulsed with other operands during busy -> ignored; first result unchanged, no extra done.
  - start in the done cycle -> accepted; second done follows 26 cycles later.
- Reset: assert rst at cycle 10 of an operation -> outputs immediately zero, state IDLE, no done ever; a fresh start afterwards completes normally.
